// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared types for the child scan sequencer.
// Holds the FSM state enum and the parameter defaults.
package scan_seq_pkg;

  localparam int DEF_NUM_CHILDREN   = 5;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/child_scan_sequencer_timeout.sv
// scan_timeout_counter: saturating per-request cycle counter.
// expired is high once the count reaches TIMEOUT_CYCLES-1.
module scan_timeout_counter
  import scan_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count request cycles; hold at LAST instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/child_scan_sequencer.sv
// child_scan_sequencer: walks the children one request at a time.
// Optional feature: define SCAN_SEQ_TIMEOUT_EN for per-child timeout.
module child_scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int NUM_CHILDREN   = DEF_NUM_CHILDREN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic [NUM_CHILDREN-1:0] child_req,
  input  logic [NUM_CHILDREN-1:0] child_ack,
  output logic                    busy,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [NUM_CHILDREN-1:0] ack_mask,
  output logic [NUM_CHILDREN-1:0] timeout_mask
);

  localparam int IW = $clog2(NUM_CHILDREN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHILDREN - 1);

  if (NUM_CHILDREN < 2 || NUM_CHILDREN > 32 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("child_scan_sequencer: parameter out of range");
  end

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_CHILDREN-1:0] ack_q, ack_d;
  logic [NUM_CHILDREN-1:0] to_q, to_d;
  logic                    hit;
  logic                    expired;

`ifdef SCAN_SEQ_TIMEOUT_EN
  scan_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != REQ),
    .enable (state_q == REQ),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State, index and outcome masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ack_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
    end
  end

  // Next state; ack beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    to_d    = to_q;
    hit     = child_ack[idx_q];
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = REQ;
          idx_d   = '0;
          ack_d   = '0;
          to_d    = '0;
        end
      end
      REQ: begin
        if (hit) begin
          ack_d[idx_q] = 1'b1;
        end else if (expired) begin
          to_d[idx_q] = 1'b1;
        end
        if (hit || expired) begin
          state_d = (idx_q == LAST_IDX) ? DONE : GAP;
        end
      end
      GAP: begin
        idx_d   = idx_q + 1'b1;
        state_d = REQ;
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done_valid   = (state_q == DONE);
  assign child_req    = (state_q == REQ) ?
                        (NUM_CHILDREN'(1) << idx_q) : '0;
  assign ack_mask     = ack_q;
  assign timeout_mask = to_q;

endmodule

// File: doc/child_scan_sequencer.md
# child_scan_sequencer

Sequential control stage that sits directly upstream of a root module's five child instances. It accepts one scan request, then walks the children in index order. For each child it raises a one-hot request, waits for that child's acknowledge (or a timeout), and records the per-child outcome. When the last child is done it returns a single completion report to the requester under a valid/ready handshake.

## Interface

Parameters:
- NUM_CHILDREN, 5, number of child instances scanned; legal range 2..32.
- TIMEOUT_CYCLES, 16, maximum cycles a child request stays asserted without acknowledge; legal range 2..65535.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  requester asks for a scan.
- start_ready  output  1  high only in IDLE.
- child_req  output  NUM_CHILDREN  one-hot request to the currently selected child; all zero outside REQ.
- child_ack  input  NUM_CHILDREN  per-child acknowledge; only the bit of the selected child is sampled.
- busy  output  1  high in every state except IDLE.
- done_valid  output  1  completion report available.
- done_ready  input  1  requester consumes the report.
- ack_mask  output  NUM_CHILDREN  bit i set if child i acknowledged.
- timeout_mask  output  NUM_CHILDREN  bit i set if child i timed out.

## Operation

- FSM states:
  - IDLE: start_ready=1. On start_valid: clear both masks, set idx=0, go to REQ.
  - REQ: child_req = 1<<idx; the timeout counter increments each cycle.
    - child_ack[idx]=1: set ack_mask[idx].
    - Counter reaches TIMEOUT_CYCLES-1 with no ack: set timeout_mask[idx].
    - After either event: if idx==NUM_CHILDREN-1 go to DONE, else go to GAP.
  - GAP: one cycle with child_req all zero. Increment idx, clear the counter, go to REQ.
  - DONE: done_valid=1; masks held stable. On done_ready go to IDLE.
- Ack and timeout in the same cycle: ack wins (ack_mask set, timeout_mask clear).
- An ack already high in the first REQ cycle counts; the request is then one cycle long.
- Acks on non-selected children are ignored in every state.
- start_valid outside IDLE is ignored; there is no queuing.
- Masks stay valid after DONE→IDLE until the next start is accepted.
- Invariant: ack_mask & timeout_mask == 0. In DONE, ack_mask | timeout_mask is all ones.
- idx width is $clog2(NUM_CHILDREN). The counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and does not wrap.

## Timing

- Reset values: state=IDLE, start_ready=1, busy=0, child_req=0, done_valid=0, ack_mask=0, timeout_mask=0, idx=0, counter=0.
- Start accepted at edge T0 → child_req[0] high in cycle T0+1.
- Per child: request length = (ack cycle − first REQ cycle + 1) cycles, at most TIMEOUT_CYCLES. This is followed by one GAP cycle, except after the last child.
- All children ack immediately (N=5): req pulses in cycles 1,3,5,7,9 after accept; done_valid in cycle 10.
- A rst asserted in any state reaches full reset values at the next edge; child_req drops in the cycle after that edge. A partial report is never presented.
- done_valid, once high, holds until the done_ready handshake.

## Configuration

- SCAN_SEQ_TIMEOUT_EN defined:
  - Timeout counter present; a child that never acks is marked in timeout_mask after TIMEOUT_CYCLES.
- SCAN_SEQ_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely for ack.
  - timeout_mask is tied to zero. TIMEOUT_CYCLES is accepted but unused.

## Structure

- Package scan_seq_pkg holds:
  - the state enum (IDLE, REQ, GAP, DONE);
  - default constants DEF_NUM_CHILDREN=5 and DEF_TIMEOUT_CYCLES=16.
- One sub-module, scan_timeout_counter: clear/enable inputs, expired output, width from TIMEOUT_CYCLES. It is instantiated only under SCAN_SEQ_TIMEOUT_EN.

## Test plan

- Reset, then idle: all outputs at reset values; start_ready=1, busy=0.
- Start; each child acks in its first REQ cycle → req pulses in cycles 1,3,5,7,9; done_valid in cycle 10; ack_mask=5'b11111, timeout_mask=0.
- Child 2 never acks (TIMEOUT_CYCLES=16) → child_req[2] high exactly 16 cycles; report ack_mask=5'b11011, timeout_mask=5'b00100. Without the macro, the FSM is still in REQ at idx=2 after 100 cycles.
- Child 3 acks on exactly the 16th REQ cycle → ack_mask[3]=1, timeout_mask[3]=0.
- Acks on children 1–4 held high while idx=0 and child 0 delays 3 cycles → child_req[0] lasts 3 cycles; other acks cause no premature step.
- rst pulsed while idx=2 in REQ, and separately in DONE with done_ready=0 → next cycle IDLE, all masks 0, child_req=0, done_valid=0. A new start then runs a clean full scan.
